// File: rtl/spi_cmd_decoder_pkg.sv
// spi_cmd_decoder_pkg: opcodes, FSM states and widths shared by the DDS command path.
package spi_cmd_decoder_pkg;
    localparam int DEF_NUM_VOICES = 8;
    localparam int DEF_FREQ_W     = 16;
    localparam int DEF_ENV_W      = 8;
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_CLR_ERR = 8'hFE;
    localparam logic [7:0] OP_ALL_OFF = 8'hFF;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FREQ_HI = 3'd1,
        S_FREQ_LO = 3'd2,
        S_ENV_B   = 3'd3
    } state_e;
    // FREQ (odd) and ENV (even) opcodes for the same voice share (op-1)/2.
    function automatic logic [7:0] op_voice(input logic [7:0] op);
        return (op - 8'd1) >> 1;
    endfunction
endpackage

// File: rtl/spi_cmd_decoder_if.sv
// spi_cmd_decoder_if: byte stream from the SPI slave into the command decoder.
interface spi_cmd_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/spi_cmd_decoder_cmd_gap_timer.sv
// cmd_gap_timer: counts idle cycles while enabled; pulses expire on the TIMEOUT_CYC-th one.
module cmd_gap_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = (clear || !enable) ? '0 : cnt_q + 1'b1;
        expire = enable && !clear && cnt_q == LAST;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses opcode+payload byte frames into per-voice tuning words and
// envelope levels, with atomic word updates, sticky error and an inter-byte gap timeout.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int NUM_VOICES  = DEF_NUM_VOICES,
    parameter int FREQ_W      = DEF_FREQ_W,
    parameter int ENV_W       = DEF_ENV_W,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    spi_cmd_decoder_if.slave             st,
    output logic [NUM_VOICES*FREQ_W-1:0] freq_out,
    output logic [NUM_VOICES*ENV_W-1:0]  env_out,
    output logic [NUM_VOICES-1:0]        freq_upd,
    output logic [NUM_VOICES-1:0]        env_upd,
    output logic                         cmd_error,
    output logic [7:0]                   status_led
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam logic [7:0] MAX_OP = 8'(2 * NUM_VOICES);
    state_e                state_q, state_d;
    logic [FREQ_W-1:0]     freq_q [NUM_VOICES];
    logic [FREQ_W-1:0]     freq_d [NUM_VOICES];
    logic [ENV_W-1:0]      env_q [NUM_VOICES];
    logic [ENV_W-1:0]      env_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] fupd_q, fupd_d, eupd_q, eupd_d;
    logic                  err_q, err_d;
    logic [3:0]            op_q, op_d;
    logic [VW-1:0]         voice_q, voice_d;
    logic [7:0]            hi_q, hi_d;
    logic                  expire, in_range, op_freq, op_env;

    cmd_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (st.rx_valid),
        .enable (state_q != S_IDLE),
        .expire (expire)
    );

    assign in_range = st.rx_data != 8'd0 && st.rx_data <= MAX_OP;
    assign op_freq  = in_range && st.rx_data[0];
    assign op_env   = in_range && !st.rx_data[0];

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        env_d   = env_q;
        fupd_d  = '0;
        eupd_d  = '0;
        err_d   = err_q;
        op_d    = op_q;
        voice_d = voice_q;
        hi_d    = hi_q;
        if (st.rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    op_d    = st.rx_data[3:0];
                    voice_d = VW'(op_voice(st.rx_data));
                    if (op_freq) state_d = S_FREQ_HI;
                    else if (op_env) state_d = S_ENV_B;
                    else if (st.rx_data == OP_CLR_ERR) err_d = 1'b0;
                    else if (st.rx_data == OP_ALL_OFF) begin
                        env_d  = '{default: '0};
                        eupd_d = '1;
                    end
                    else if (st.rx_data != OP_NOP) err_d = 1'b1;
                end
                S_FREQ_HI: begin
                    hi_d    = st.rx_data;
                    state_d = S_FREQ_LO;
                end
                S_FREQ_LO: begin
                    // Whole word lands in one edge; the high byte waited in the shadow.
                    freq_d[voice_q] = {hi_q, st.rx_data};
                    fupd_d[voice_q] = 1'b1;
                    state_d         = S_IDLE;
                end
                S_ENV_B: begin
                    env_d[voice_q]  = ENV_W'(st.rx_data);
                    eupd_d[voice_q] = 1'b1;
                    state_d         = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        else if (expire) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            freq_q  <= '{default: '0};
            env_q   <= '{default: '0};
            fupd_q  <= '0;
            eupd_q  <= '0;
            err_q   <= 1'b0;
            op_q    <= '0;
            voice_q <= '0;
            hi_q    <= '0;
        end
        else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            env_q   <= env_d;
            fupd_q  <= fupd_d;
            eupd_q  <= eupd_d;
            err_q   <= err_d;
            op_q    <= op_d;
            voice_q <= voice_d;
            hi_q    <= hi_d;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign freq_out[v*FREQ_W +: FREQ_W] = freq_q[v];
        assign env_out[v*ENV_W +: ENV_W]    = env_q[v];
    end

    assign st.rx_ready = ~reset;
    assign freq_upd    = fupd_q;
    assign env_upd     = eupd_q;
    assign cmd_error   = err_q;
    assign status_led  = {err_q, state_q, op_q};
endmodule
